// File: rtl/out_arb_6to1.sv
`default_nettype none
//==============================================================================
// Module  : out_arb_6to1
// Brief   : Round-robin wormhole output arbiter for the 6-port router.
//           Optional lock watchdog enabled by defining OUTARB_WATCHDOG_EN.
// Revision: 1.0
//==============================================================================
module out_arb_6to1 #(
  parameter int unsigned WDT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] req,
  input  logic [5:0] tail,
  input  logic       ready_dn,
  output logic [5:0] mux_sel,
  output logic       busy,
  output logic       fire,
  output logic       wdt_err
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [5:0] sel_q, sel_d;

  logic       win_vld;
  logic [2:0] win_idx;
  logic [3:0] cand;
  logic       tail_fire;
  logic       wdt_release;

  assign fire      = |(sel_q & req) & ready_dn;
  assign tail_fire = fire & |(sel_q & tail);

  // First requester at or after ptr, wrapping 5 -> 0.
  always_comb begin
    win_vld = 1'b0;
    win_idx = 3'd0;
    cand    = 4'd0;
    for (int k = 0; k < 6; k++) begin
      cand = {1'b0, ptr_q} + 4'(k);
      if (cand >= 4'd6) begin
        cand = cand - 4'd6;
      end
      if (!win_vld && req[cand[2:0]]) begin
        win_vld = 1'b1;
        win_idx = cand[2:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          state_d = ST_LOCKED;
          sel_d   = 6'd1 << win_idx;
          ptr_d   = (win_idx == 3'd5) ? 3'd0 : win_idx + 3'd1;
        end
      end
      ST_LOCKED: begin
        if (tail_fire || wdt_release) begin
          state_d = ST_IDLE;
          sel_d   = 6'd0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= 3'd0;
      sel_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
    end
  end

  assign mux_sel = sel_q;
  assign busy    = (state_q == ST_LOCKED);

`ifdef OUTARB_WATCHDOG_EN
  logic [15:0] wdt_q, wdt_d;
  logic        wdt_err_q;

  // A fire always wins over expiry, so the count only advances on stalls.
  always_comb begin
    wdt_d       = 16'd0;
    wdt_release = 1'b0;
    if (state_q == ST_LOCKED && !fire) begin
      if (wdt_q == 16'(WDT_CYCLES)) begin
        wdt_release = 1'b1;
      end else begin
        wdt_d = wdt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wdt_q     <= 16'd0;
      wdt_err_q <= 1'b0;
    end else begin
      wdt_q     <= wdt_d;
      wdt_err_q <= wdt_release;
    end
  end

  assign wdt_err = wdt_err_q;
`else
  logic [15:0] unused_wdt_cycles;
  assign unused_wdt_cycles = 16'(WDT_CYCLES);
  assign wdt_release       = 1'b0;
  assign wdt_err           = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/out_arb_6to1.md
# out_arb_6to1

Per-output-port wormhole switch allocator for the 6-port router. It arbitrates round-robin among the six input ports requesting this output. The winner's grant is locked from head flit to tail flit. The registered one-hot `mux_sel` it produces drives the output's flit data mux and the `mux_ready_6to1` ready return path. There is one instance per output port, sitting between the route-compute results and the crossbar.

## Interface
Parameters:
- `WDT_CYCLES`, default 255: stall limit in cycles for the lock watchdog. Used only with `OUTARB_WATCHDOG_EN`. Range 1..65535.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge
- `rst`  in  1  reset, synchronous and active-high
- `req`  in  6  per-input-port valid flit routed to this output
- `tail`  in  6  per-input-port tail marker, qualified by `req[i]`; single-flit packets assert head and tail together
- `ready_dn`  in  1  downstream (output buffer / next hop) ready
- `mux_sel`  out  6  registered one-hot grant; all zeros means no grant
- `busy`  out  1  registered; 1 while in LOCKED
- `fire`  out  1  combinational; a flit transfers this cycle
- `wdt_err`  out  1  registered one-cycle pulse on watchdog release; tied 0 without the macro

## Operation
- States: IDLE and LOCKED. Round-robin pointer `ptr` holds a value 0..5.
- `fire = |(mux_sel & req) & ready_dn`.
- IDLE:
  - If `req` is non-zero, pick the first requesting port i, searching `ptr`, `ptr+1`, ... modulo 6 (5 wraps to 0; pointer values 6 and 7 never occur).
  - Next cycle: `mux_sel = 1<<i`, `busy = 1`, state = LOCKED, `ptr = (i+1) mod 6`.
  - If `req` is zero, stay in IDLE; `mux_sel` and `ptr` are unchanged.
- LOCKED, granted port g:
  - `mux_sel` is held. `req` on other ports is ignored.
  - If `req[g]` deasserts without a tail, the lock is held (wormhole): no transfer, no re-arbitration.
  - When `fire & tail[g]`: next cycle `mux_sel = 0`, `busy = 0`, state = IDLE.
  - A `fire` without tail keeps the lock.
- No arbitration happens in the cycle a tail transfers. The earliest new grant is 2 cycles after the tail transfer cycle.
- `ready_dn` low stalls the transfer. Grant and state are unaffected.
- Only the granted port's `tail` is examined. Tails on other ports are ignored.

## Timing
- Reset values: `mux_sel = 6'b000000`, `busy = 0`, `wdt_err = 0`, `ptr = 0`, state = IDLE, watchdog counter = 0.
- Reset applied mid-packet forces all reset values on the next edge and drops the lock. The arbiter does not track packet integrity across reset.
- Request to grant: 1 cycle. A request sampled at edge N gives `mux_sel` valid after edge N+1. The first transfer can happen in cycle N+1.
- Throughput when locked: 1 flit per cycle while `req[g]` and `ready_dn` are high.
- Back-to-back single-flit packets: one grant every 2 cycles per output.
- `mux_sel` is always one-hot or zero, never multi-hot.

## Configuration
- With `OUTARB_WATCHDOG_EN` defined:
  - A 16-bit stall counter increments each LOCKED cycle without `fire`.
  - It clears on `fire`, on entering LOCKED, and on reset.
  - When the counter reaches `WDT_CYCLES`, the next cycle gives `mux_sel = 0`, `busy = 0`, state = IDLE, and `wdt_err = 1` for exactly 1 cycle. `ptr` is unchanged.
  - A `fire` in the same cycle the limit is reached takes precedence: counter clears, no release.
- Without the macro: no counter is built, `wdt_err` is constant 0, and a lock persists until the tail transfers.

## Test plan
- Reset: drive `rst = 1` with `req = 6'h3F` for 2 cycles. Required: `mux_sel = 0`, `busy = 0`, `wdt_err = 0` throughout. After release, the first grant is `6'b000001`, since `ptr = 0`.
- Single-flit packet: `req = 6'b000100`, `tail = 6'b000100`, `ready_dn = 1` at cycle 0. Required: `mux_sel = 6'b000100` and `fire = 1` in cycle 1, then `mux_sel = 0` in cycle 2.
- Fairness and wrap: all six ports continuously send single-flit packets. Required grant order is 0,1,2,3,4,5,0, spaced 2 cycles apart. Then, with `ptr = 5`, request only ports 0 and 5. Required: 5 is granted first, then 0.
- Lock and backpressure:
  - Port 1 sends a 3-flit packet while port 4 requests continuously.
  - Hold `ready_dn = 0` for 2 cycles mid-packet, and drop `req[1]` for 1 cycle.
  - Required: `mux_sel = 6'b000010` is held until the tail fires, with exactly 3 `fire` pulses.
  - Port 4 is granted 2 cycles after the tail transfer.
- Reset mid-packet: assert `rst` after the 2nd flit of a 4-flit packet. Required: `mux_sel = 0` on the next edge. After reset, arbitration restarts from `ptr = 0`.
- Watchdog (macro on, `WDT_CYCLES = 8`): lock port 3, then drop `req[3]`. Required: after 8 stall cycles, `wdt_err` pulses for 1 cycle and `mux_sel` clears. With the macro off, the lock holds for at least 1000 cycles.
